tap_classifier: RTL and testbench
=================================

Name: tap_classifier

Overview:
- Sits directly downstream of the pushbutton synchronizer/rising-edge detector.
- Consumes its single-cycle rise_edge pulses and classifies each press as a single tap or a double tap, with a holdoff window that rejects bounce.
- Presents each result to the command logic over a valid/ready handshake.
- Flags events dropped because the consumer stalled.

Parameters:
HOLDOFF_CYC, 16, cycles after each accepted edge during which further rise_edge pulses are ignored (bounce reject); must be >= 1
TAP_WIN_CYC, 64, cycles after the first holdoff in which a second edge makes a double tap; must be >= 1
CNT_W, $clog2(max(HOLDOFF_CYC,TAP_WIN_CYC))+1, internal counter width (derived; not overridden)

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  synchronous active-low reset, sampled on posedge clk
rise_edge  input  1  single-cycle press pulse from the synchronizer, already in clk domain
evt_rdy  input  1  consumer ready
evt_vld  output  1  event valid, held until accepted
evt_type  output  2  2'b01 single tap, 2'b10 double tap, 2'b00 when no event held
busy  output  1  high whenever classifier state != IDLE
ovfl  output  1  sticky: an event was dropped because evt_vld was pending and not accepted

Behaviour:
- Reset: rst_n low at a posedge forces state IDLE, counter 0, evt_vld 0, evt_type 2'b00, busy 0, ovfl 0. A reset in any state aborts classification with no event emitted.
- States: IDLE, HOLD1, WAIT2, HOLD2.
- IDLE: rise_edge at posedge k -> HOLD1 and clear counter.
- HOLD1: occupies the next HOLDOFF_CYC posedges (k+1 .. k+HOLDOFF_CYC). rise_edge is ignored. At the last one -> WAIT2 and clear counter.
- WAIT2: occupies up to TAP_WIN_CYC posedges.
  - rise_edge at any of them -> HOLD2 and clear counter.
  - No edge by the last one -> emit SINGLE and return to IDLE.
  - If rise_edge coincides with the final window posedge, the edge wins -> HOLD2, no SINGLE.
- HOLD2: HOLDOFF_CYC posedges, edges ignored (a third tap is absorbed). At the last one -> emit DOUBLE and return to IDLE.
- Edge in the cycle after returning to IDLE: starts a new classification normally.
- Emit mechanics: on the emitting posedge, evt_type is loaded and evt_vld is set, both visible after that edge. Latency is fixed by the state timing above.
- Handshake:
  - evt_vld and evt_type are held stable until a posedge with evt_vld & evt_rdy.
  - After that posedge, evt_vld is 0 and evt_type is 2'b00, unless a new emit occurs on the same posedge. In that case the new type is loaded and evt_vld stays 1.
  - evt_rdy is ignored while evt_vld is 0.
- Overflow: an emit while evt_vld=1 and evt_rdy=0 drops the new event. The held event is unchanged and ovfl is set to 1 until reset.
- busy: combinational decode, state != IDLE.
- Counter: saturates and never wraps. Compare against parameter-1 in CNT_W bits.

Test Plan:
Use HOLDOFF_CYC=4, TAP_WIN_CYC=8, evt_rdy tied 1 unless stated; k = posedge where the first rise_edge is sampled.
1. Reset mid-HOLD1 (rst_n low at k+2) -> state IDLE, busy 0, no evt_vld ever for that press; after release, a new edge classifies normally.
2. Single tap: edge at k, none after -> busy 1 from k+1; evt_vld=1, evt_type=01 after posedge k+12 for exactly one cycle.
3. Double tap with bounce: edges at k, k+2 (ignored), k+7 -> evt_type=10 after posedge k+11; no 01 event.
4. Window boundary: edge at k and at k+12 -> DOUBLE emitted after posedge k+16; edge at k and k+13 -> SINGLE after k+12, then a new classification starts from the k+13 edge.
5. Back-pressure: evt_rdy=0, single tap then a second single tap -> first event 01 held stable, ovfl=1 at the second emit. Raise evt_rdy -> evt_vld drops next cycle, evt_type=00, ovfl stays 1.
6. Accept-and-emit same posedge: hold evt_rdy=0 with a 01 pending, raise evt_rdy exactly on a DOUBLE emit posedge -> evt_vld stays 1, evt_type becomes 10, ovfl stays 0.

Source files
------------

// File: rtl/tap_classifier.sv
// tap_classifier: turns single-cycle press pulses into single/double tap
// events, ignoring bounce during holdoff windows, and hands each event to
// the command logic over a valid/ready handshake.
module tap_classifier #(
  parameter int HOLDOFF_CYC = 16,
  parameter int TAP_WIN_CYC = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rise_edge,
  input  logic       evt_rdy,
  output logic       evt_vld,
  output logic [1:0] evt_type,
  output logic       busy,
  output logic       ovfl
);

  // Counter wide enough for the longer of the two windows, plus headroom.
  localparam int MAX_CYC = (HOLDOFF_CYC > TAP_WIN_CYC) ? HOLDOFF_CYC : TAP_WIN_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYC - 1);
  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(TAP_WIN_CYC - 1);

  localparam logic [1:0] TYPE_NONE   = 2'b00;
  localparam logic [1:0] TYPE_SINGLE = 2'b01;
  localparam logic [1:0] TYPE_DOUBLE = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD1 = 2'd1,
    WAIT2 = 2'd2,
    HOLD2 = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             emit;
  logic [1:0]       emit_type;

  // Saturating increment: the counter parks at all-ones rather than wrapping.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  // Decode whether this posedge produces an event, and which kind.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    emit      = 1'b0;
    emit_type = TYPE_NONE;
    if (state == WAIT2 && !rise_edge && cnt == WIN_LAST) begin
      emit      = 1'b1;
      emit_type = TYPE_SINGLE;
    end else if (state == HOLD2 && cnt == HOLD_LAST) begin
      emit      = 1'b1;
      emit_type = TYPE_DOUBLE;
    end
  end

  // Classification FSM: holdoff, tap window, second holdoff.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (rise_edge) state <= HOLD1;
        end
        HOLD1: begin
          if (cnt == HOLD_LAST) begin
            state <= WAIT2;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        WAIT2: begin
          // An edge on the final window cycle still counts as the second tap.
          if (rise_edge) begin
            state <= HOLD2;
            cnt   <= '0;
          end else if (cnt == WIN_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        HOLD2: begin
          if (cnt == HOLD_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Event holding register with valid/ready handshake and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_vld  <= 1'b0;
      evt_type <= TYPE_NONE;
      ovfl     <= 1'b0;
    end else if (emit) begin
      if (!evt_vld || evt_rdy) begin
        // Slot is free or being freed on this edge: load the new event.
        evt_vld  <= 1'b1;
        evt_type <= emit_type;
      end else begin
        // Consumer stalled with an event pending: drop the new one.
        ovfl <= 1'b1;
      end
    end else if (evt_vld && evt_rdy) begin
      evt_vld  <= 1'b0;
      evt_type <= TYPE_NONE;
    end
  end

  // Busy whenever a classification is in progress.
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_tap_classifier.sv
// Self-checking bench for tap_classifier with HOLDOFF_CYC=4, TAP_WIN_CYC=8.
// Each step drives inputs, lets one posedge sample them, then checks the
// registered outputs 1 time unit after that edge.
module tb_tap_classifier;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rise_edge = 1'b0;
  logic       evt_rdy = 1'b1;
  logic       evt_vld;
  logic [1:0] evt_type;
  logic       busy;
  logic       ovfl;

  int n_cmp = 0;
  int n_bad = 0;

  tap_classifier #(
    .HOLDOFF_CYC(4),
    .TAP_WIN_CYC(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rise_edge(rise_edge),
    .evt_rdy  (evt_rdy),
    .evt_vld  (evt_vld),
    .evt_type (evt_type),
    .busy     (busy),
    .ovfl     (ovfl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rise;
    logic       rdy;
    logic       vld;
    logic [1:0] typ;
    logic       bsy;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rise, input logic rdy, input logic vld,
                              input logic [1:0] typ, input logic bsy, input logic ovf);
    vec_t v;
    v.rise = rise; v.rdy = rdy; v.vld = vld; v.typ = typ; v.bsy = bsy; v.ovf = ovf;
    tbl.push_back(v);
  endfunction

  // One posedge with the given inputs; outputs are stable 1 unit later.
  task automatic tick(input logic rise, input logic rdy);
    rise_edge = rise;
    evt_rdy   = rdy;
    @(posedge clk);
    #1;
    rise_edge = 1'b0;
  endtask

  task automatic check(input string name, input logic vld, input logic [1:0] typ,
                       input logic bsy, input logic ovf);
    n_cmp++;
    if (evt_vld !== vld || evt_type !== typ || busy !== bsy || ovfl !== ovf) begin
      n_bad++;
      $display("FAIL %s: got vld=%b type=%b busy=%b ovfl=%b, want vld=%b type=%b busy=%b ovfl=%b",
               name, evt_vld, evt_type, busy, ovfl, vld, typ, bsy, ovf);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1'b0, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    // ---------------- table: single tap, then double tap with bounce ----------
    // Vector i is applied at posedge k+i of its sequence.
    add(1, 1, 0, 2'b00, 1, 0);                       // k: edge accepted
    for (int i = 1; i <= 11; i++) add(0, 1, 0, 2'b00, 1, 0);
    add(0, 1, 1, 2'b01, 0, 0);                       // k+12: SINGLE
    add(0, 1, 0, 2'b00, 0, 0);                       // k+13: accepted, cleared
    add(1, 1, 0, 2'b00, 1, 0);                       // k: second sequence
    add(0, 1, 0, 2'b00, 1, 0);                       // k+1
    add(1, 1, 0, 2'b00, 1, 0);                       // k+2: bounce ignored
    for (int i = 3; i <= 6; i++) add(0, 1, 0, 2'b00, 1, 0);
    add(1, 1, 0, 2'b00, 1, 0);                       // k+7: second tap
    for (int i = 8; i <= 10; i++) add(0, 1, 0, 2'b00, 1, 0);
    add(0, 1, 1, 2'b10, 0, 0);                       // k+11: DOUBLE
    for (int i = 12; i <= 16; i++) add(0, 1, 0, 2'b00, 0, 0);  // no late SINGLE

    do_reset();
    check("reset_state", 0, 2'b00, 0, 0);

    foreach (tbl[i]) begin
      tick(tbl[i].rise, tbl[i].rdy);
      check($sformatf("table[%0d]", i), tbl[i].vld, tbl[i].typ, tbl[i].bsy, tbl[i].ovf);
    end

    // ---------------- reset mid-HOLD1 ----------------------------------------
    do_reset();
    tick(1, 1);
    tick(0, 1);
    check("hold1_busy", 0, 2'b00, 1, 0);
    rst_n = 1'b0;
    tick(0, 1);                                      // k+2 with reset asserted
    rst_n = 1'b1;
    check("mid_reset_idle", 0, 2'b00, 0, 0);
    for (int i = 0; i < 14; i++) begin
      tick(0, 1);
      check($sformatf("aborted_no_evt[%0d]", i), 0, 2'b00, 0, 0);
    end
    tick(1, 1);
    for (int i = 1; i <= 11; i++) tick(0, 1);
    check("post_reset_pre", 0, 2'b00, 1, 0);
    tick(0, 1);
    check("post_reset_single", 1, 2'b01, 0, 0);
    tick(0, 1);
    check("post_reset_clear", 0, 2'b00, 0, 0);

    // ---------------- window boundary: edge at k+12 -> DOUBLE ----------------
    do_reset();
    tick(1, 1);
    for (int i = 1; i <= 11; i++) tick(0, 1);
    tick(1, 1);                                      // k+12: last window cycle
    check("edge_on_last_win", 0, 2'b00, 1, 0);
    for (int i = 13; i <= 15; i++) tick(0, 1);
    check("edge_last_pre", 0, 2'b00, 1, 0);
    tick(0, 1);                                      // k+16
    check("edge_last_double", 1, 2'b10, 0, 0);

    // ---------------- window boundary: edge at k+13 -> SINGLE then new -------
    do_reset();
    tick(1, 1);
    for (int i = 1; i <= 11; i++) tick(0, 1);
    tick(0, 1);                                      // k+12
    check("late_edge_single", 1, 2'b01, 0, 0);
    tick(1, 1);                                      // k+13: new classification
    check("late_edge_new", 0, 2'b00, 1, 0);
    for (int i = 1; i <= 11; i++) tick(0, 1);
    tick(0, 1);
    check("late_edge_single2", 1, 2'b01, 0, 0);

    // ---------------- back-pressure and overflow -----------------------------
    do_reset();
    tick(1, 0);
    for (int i = 1; i <= 11; i++) tick(0, 0);
    tick(0, 0);                                      // k+12
    check("bp_first_emit", 1, 2'b01, 0, 0);
    tick(1, 0);                                      // k+13
    check("bp_held_k13", 1, 2'b01, 1, 0);
    for (int i = 14; i <= 24; i++) tick(0, 0);
    check("bp_held_k24", 1, 2'b01, 1, 0);
    tick(0, 0);                                      // k+25: dropped emit
    check("bp_ovfl", 1, 2'b01, 0, 1);
    tick(0, 0);
    check("bp_still_held", 1, 2'b01, 0, 1);
    tick(0, 1);
    check("bp_accept", 0, 2'b00, 0, 1);
    tick(0, 1);
    check("bp_ovfl_sticky", 0, 2'b00, 0, 1);

    // ---------------- accept and emit on the same posedge --------------------
    do_reset();
    tick(1, 0);
    for (int i = 1; i <= 11; i++) tick(0, 0);
    tick(0, 0);                                      // k+12: 01 pending
    check("ae_pending", 1, 2'b01, 0, 0);
    for (int i = 13; i <= 23; i++) tick(i == 13 || i == 20, 0);
    check("ae_pre", 1, 2'b01, 1, 0);
    tick(0, 1);                                      // k+24: DOUBLE + accept
    check("ae_same_edge", 1, 2'b10, 0, 0);
    tick(0, 1);
    check("ae_drain", 0, 2'b00, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
